// File: rtl/alu_muldiv_seq_pkg.sv
// Shared op codes, ALU control encodings and sequencer states for the M-extension unit.
package alu_muldiv_seq_pkg;

    localparam logic [1:0] OP_MUL     = 2'b00;
    localparam logic [1:0] OP_MUL_ALT = 2'b01;
    localparam logic [1:0] OP_DIVU    = 2'b10;
    localparam logic [1:0] OP_REMU    = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_RUN,
        S_DIV_CMP,
        S_DIV_SUB,
        S_DONE
    } state_t;

    function automatic logic is_mul(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_MUL_ALT);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide sequencer.
interface alu_muldiv_seq_if #(
    parameter int width = 32
);
    logic             start;
    logic [1:0]       op;
    logic [width-1:0] opA;
    logic [width-1:0] opB;
    logic             busy;
    logic             done;
    logic [width-1:0] result;

    modport master (output start, op, opA, opB, input busy, done, result);
    modport slave  (input start, op, opA, opB, output busy, done, result);
endinterface

// File: rtl/alu_muldiv_seq_alu.sv
// Shared combinational ALU; SLT is an unsigned compare returning 1 when src_a < src_b.
module alu_muldiv_seq_alu
    import alu_muldiv_seq_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [2:0]       alu_control,
    input  logic [width-1:0] src_a,
    input  logic [width-1:0] src_b,
    output logic [width-1:0] alu_result
);

    always_comb begin
        alu_result = '0;
        unique case (alu_control)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(width-1){1'b0}}, (src_a < src_b)};
            default: alu_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential MUL/DIVU/REMU on one shared ALU; fixed latency W+1 (MUL), 2W+1 (DIV), 1 (div by zero).
// No backpressure: start is taken only in IDLE, done is a one-cycle pulse the core must capture.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_muldiv_seq_if.slave  bus
);

    localparam int CW = $clog2(width) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [width-1:0] b_q, acc, mc, mp, rem, quo, result_q;
    logic [CW-1:0]    cnt;
    logic             sub_flag, busy_q, done_q;

    logic [2:0]       alu_control;
    logic [width-1:0] src_a, src_b, alu_result;
    logic [width-1:0] rs, div_rem_nxt, div_quo_nxt;
    logic             last;

    alu_muldiv_seq_alu #(.width(width)) u_alu (
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_result  (alu_result)
    );

    assign rs          = {rem[width-2:0], quo[width-1]};
    assign last        = (cnt == CNT_LAST);
    assign div_rem_nxt = sub_flag ? alu_result : rem;
    assign div_quo_nxt = {quo[width-1:1], sub_flag};

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        alu_control = ALU_ADD;
        src_a       = '0;
        src_b       = '0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (is_mul(bus.op))       state_nxt = S_MUL_RUN;
                    else if (bus.opB == '0)   state_nxt = S_DONE;
                    else                      state_nxt = S_DIV_CMP;
                end
            end
            S_MUL_RUN: begin
                src_a = acc;
                src_b = mc;
                if (last) state_nxt = S_DONE;
            end
            S_DIV_CMP: begin
                // A set rem MSB means the shifted value exceeds any W-bit divisor.
                if (!rem[width-1]) begin
                    alu_control = ALU_SLT;
                    src_a       = rs;
                    src_b       = b_q;
                end
                state_nxt = S_DIV_SUB;
            end
            S_DIV_SUB: begin
                if (sub_flag) begin
                    alu_control = ALU_SUB;
                    src_a       = rem;
                    src_b       = b_q;
                end
                state_nxt = last ? S_DONE : S_DIV_CMP;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            b_q      <= '0;
            acc      <= '0;
            mc       <= '0;
            mp       <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            sub_flag <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        b_q  <= bus.opB;
                        acc  <= '0;
                        mc   <= bus.opA;
                        mp   <= bus.opB;
                        rem  <= '0;
                        quo  <= bus.opA;
                        cnt  <= '0;
                        if (!is_mul(bus.op) && (bus.opB == '0)) begin
                            done_q   <= 1'b1;
                            result_q <= (bus.op == OP_REMU) ? bus.opA : '1;
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                end
                S_MUL_RUN: begin
                    if (mp[0]) acc <= alu_result;
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= mp[0] ? alu_result : acc;
                    end
                end
                S_DIV_CMP: begin
                    sub_flag <= rem[width-1] | (alu_result == '0);
                    rem      <= rs;
                    quo      <= quo << 1;
                end
                S_DIV_SUB: begin
                    rem <= div_rem_nxt;
                    quo <= div_quo_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= (op_q == OP_DIVU) ? div_quo_nxt : div_rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq: results, latency, busy span, done pulse and reset.
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq_if #(.width(32)) bus ();

    alu_muldiv_seq #(.width(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int poke_at);
        int busy_cycles;
        int done_at;
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.opA   = ~a;
        bus.opB   = ~b;
        done_at     = -1;
        busy_cycles = 0;
        for (int c = 1; c <= 200 && done_at < 0; c++) begin
            @(negedge clk);
            if (c == poke_at) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.opA   = 32'h0000_0055;
                bus.opB   = 32'h0000_0003;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cycles++;
            if (bus.done) done_at = c;
        end
        bus.start = 1'b0;
        check_vec({tag, " latency"}, done_at, exp_lat);
        check_vec({tag, " result"}, bus.result, exp_res);
        check_vec({tag, " busy cycles"}, busy_cycles, exp_lat - 1);
        @(negedge clk);
        check_vec({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
        check_vec({tag, " result hold"}, bus.result, exp_res);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.opA   = '0;
        bus.opB   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("reset busy", {31'd0, bus.busy}, 32'd0);
        check_vec("reset done", {31'd0, bus.done}, 32'd0);
        check_vec("reset result", bus.result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mul 7*6",        OP_MUL,     32'd7,          32'd6,          32'd42,         33, 0);
        run_op("mul max*max",    OP_MUL,     32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33, 0);
        run_op("mul ovf",        OP_MUL_ALT, 32'h8000_0000,  32'd2,          32'h0000_0000,  33, 0);
        run_op("mul alias",      OP_MUL_ALT, 32'h1234_5678,  32'h0000_0010,  32'h2345_6780,  33, 0);
        run_op("divu 100/7",     OP_DIVU,    32'd100,        32'd7,          32'd14,         65, 0);
        run_op("remu 100/7",     OP_REMU,    32'd100,        32'd7,          32'd2,          65, 0);
        run_op("divu big",       OP_DIVU,    32'hFFFF_FFFF,  32'h8000_0001,  32'h0000_0001,  65, 0);
        run_op("remu big",       OP_REMU,    32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  65, 0);
        run_op("divu 7/100",     OP_DIVU,    32'd7,          32'd100,        32'd0,          65, 0);
        run_op("remu 7/100",     OP_REMU,    32'd7,          32'd100,        32'd7,          65, 0);
        run_op("divu by one",    OP_DIVU,    32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  65, 0);
        run_op("divu by zero",   OP_DIVU,    32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0);
        run_op("remu by zero",   OP_REMU,    32'd5,          32'd0,          32'd5,          1,  0);
        run_op("mul start poke", OP_MUL,     32'd7,          32'd6,          32'd42,         33, 5);

        // Abort a divide part-way through with reset.
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.opA   = 32'd100;
        bus.opB   = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check_vec("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_vec("abort busy", {31'd0, bus.busy}, 32'd0);
        check_vec("abort done", {31'd0, bus.done}, 32'd0);
        check_vec("abort result", bus.result, 32'd0);
        reset = 1'b0;
        run_op("mul 3*3 after reset", OP_MUL, 32'd3, 32'd3, 32'd9, 33, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
